sddr_init_seq: RTL and testbench

DDR3 power-up initialization sequencer. It sits directly upstream of the Xilinx DDR PHY. It drives the PHY's DDR reset and PHY reset inputs, and owns the command/address bus (CKE, RAS#, CAS#, WE#, BA, ADDR, ODT) until the JEDEC init sequence completes. After `init_done_o` rises, downstream arbitration hands the command bus to the normal controller.

---
 rtl/sddr_init_seq_if.sv | 27 ++
 rtl/sddr_init_seq.sv | 175 +++++++++++++++++
 tb/tb_sddr_init_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sddr_init_seq_if.sv
// rtl/sddr_init_seq_if.sv - DDR3 init sequencer output bundle: PHY resets and command/address pins.
// master drives the pins (sequencer), slave observes them (PHY side / arbiter).
interface sddr_init_seq_if #(
    parameter int BANK_BITS = 3,
    parameter int ROW_BITS  = 13
);
    logic                 ddr_reset_p_o;
    logic                 phy_reset_p_o;
    logic                 cke_o;
    logic                 ras_n_o;
    logic                 cas_n_o;
    logic                 we_n_o;
    logic                 odt_o;
    logic [BANK_BITS-1:0] ba_o;
    logic [ROW_BITS-1:0]  addr_o;
    logic                 init_done_o;

    modport master (
        output ddr_reset_p_o, phy_reset_p_o, cke_o, ras_n_o, cas_n_o, we_n_o,
               odt_o, ba_o, addr_o, init_done_o
    );

    modport slave (
        input  ddr_reset_p_o, phy_reset_p_o, cke_o, ras_n_o, cas_n_o, we_n_o,
               odt_o, ba_o, addr_o, init_done_o
    );
endinterface

// File: rtl/sddr_init_seq.sv
// rtl/sddr_init_seq.sv - DDR3 JEDEC power-up sequencer driving PHY resets and the command bus.
// Optional ZQCL calibration step is built only when SDDR_INIT_ZQCL_EN is defined.
module sddr_init_seq #(
    parameter int BANK_BITS      = 3,
    parameter int ROW_BITS       = 13,
    parameter int CNT_BITS       = 18,
    parameter int RESET_CYCLES   = 80000,
    parameter int CLK_CYCLES     = 16,
    parameter int CKE_CYCLES     = 200000,
    parameter int TXPR_CYCLES    = 128,
    parameter int TMRD_CYCLES    = 4,
    parameter int TMOD_CYCLES    = 12,
    parameter int TZQINIT_CYCLES = 512,
    parameter logic [ROW_BITS-1:0] MR0 = '0,
    parameter logic [ROW_BITS-1:0] MR1 = '0,
    parameter logic [ROW_BITS-1:0] MR2 = '0,
    parameter logic [ROW_BITS-1:0] MR3 = '0
) (
    input  logic             in_ddr_clock_i,
    input  logic             in_ddr_reset_n_i,
    sddr_init_seq_if.master  bus
);

    localparam logic [3:0] S_RST_HOLD  = 4'd0;
    localparam logic [3:0] S_CLK_START = 4'd1;
    localparam logic [3:0] S_CKE_WAIT  = 4'd2;
    localparam logic [3:0] S_TXPR      = 4'd3;
    localparam logic [3:0] S_MRS2      = 4'd4;
    localparam logic [3:0] S_MRS3      = 4'd5;
    localparam logic [3:0] S_MRS1      = 4'd6;
    localparam logic [3:0] S_MRS0      = 4'd7;
`ifdef SDDR_INIT_ZQCL_EN
    localparam logic [3:0] S_ZQCL      = 4'd8;
`endif
    localparam logic [3:0] S_DONE      = 4'd9;

    localparam longint CNT_LIMIT = longint'(1) << CNT_BITS;

    function automatic bit bad_len(input longint n);
        return (n < 1) || ((n - 1) >= CNT_LIMIT);
    endfunction

    if (bad_len(RESET_CYCLES) || bad_len(CLK_CYCLES) || bad_len(CKE_CYCLES) ||
        bad_len(TXPR_CYCLES)  || bad_len(TMRD_CYCLES) || bad_len(TMOD_CYCLES)) begin : g_bad_timing
        $error("sddr_init_seq: timing parameter is zero or does not fit in CNT_BITS");
    end

`ifdef SDDR_INIT_ZQCL_EN
    if (bad_len(TZQINIT_CYCLES)) begin : g_bad_tzqinit
        $error("sddr_init_seq: TZQINIT_CYCLES is zero or does not fit in CNT_BITS");
    end
    localparam logic [CNT_BITS-1:0] LD_ZQ = CNT_BITS'(TZQINIT_CYCLES - 1);
`else
    logic unused_tzqinit;
    assign unused_tzqinit = ^TZQINIT_CYCLES;
`endif

    localparam logic [CNT_BITS-1:0] LD_RST  = CNT_BITS'(RESET_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LD_CLK  = CNT_BITS'(CLK_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LD_CKE  = CNT_BITS'(CKE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LD_TXPR = CNT_BITS'(TXPR_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LD_MRD  = CNT_BITS'(TMRD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LD_MOD  = CNT_BITS'(TMOD_CYCLES - 1);

    localparam logic [ROW_BITS-1:0] ZQ_ADDR = ROW_BITS'(1) << 10;

    logic [3:0]          state;
    logic [3:0]          state_nx;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] load_nx;
    logic                first;
    logic                leave;

    // load_nx is the delay of the state being entered, not the one being left
    always_comb begin
        state_nx = S_DONE;
        load_nx  = '0;
        case (state)
            S_RST_HOLD:  begin state_nx = S_CLK_START; load_nx = LD_CLK;  end
            S_CLK_START: begin state_nx = S_CKE_WAIT;  load_nx = LD_CKE;  end
            S_CKE_WAIT:  begin state_nx = S_TXPR;      load_nx = LD_TXPR; end
            S_TXPR:      begin state_nx = S_MRS2;      load_nx = LD_MRD;  end
            S_MRS2:      begin state_nx = S_MRS3;      load_nx = LD_MRD;  end
            S_MRS3:      begin state_nx = S_MRS1;      load_nx = LD_MRD;  end
            S_MRS1:      begin state_nx = S_MRS0;      load_nx = LD_MOD;  end
`ifdef SDDR_INIT_ZQCL_EN
            S_MRS0:      begin state_nx = S_ZQCL;      load_nx = LD_ZQ;   end
            S_ZQCL:      begin state_nx = S_DONE;      load_nx = '0;      end
`else
            S_MRS0:      begin state_nx = S_DONE;      load_nx = '0;      end
`endif
            default:     begin state_nx = S_DONE;      load_nx = '0;      end
        endcase
    end

    assign leave = (cnt == '0) && (state != S_DONE);

    always_ff @(posedge in_ddr_clock_i or negedge in_ddr_reset_n_i) begin
        if (!in_ddr_reset_n_i) begin
            state <= S_RST_HOLD;
            cnt   <= LD_RST;
            first <= 1'b1;
        end else if (leave) begin
            state <= state_nx;
            cnt   <= load_nx;
            first <= 1'b1;
        end else begin
            if (state != S_DONE) begin
                cnt <= cnt - 1'b1;
            end
            first <= 1'b0;
        end
    end

    // Pins are a registered image of the state held during the previous cycle
    always_ff @(posedge in_ddr_clock_i or negedge in_ddr_reset_n_i) begin
        if (!in_ddr_reset_n_i) begin
            bus.ddr_reset_p_o <= 1'b1;
            bus.phy_reset_p_o <= 1'b1;
            bus.cke_o         <= 1'b0;
            bus.ras_n_o       <= 1'b1;
            bus.cas_n_o       <= 1'b1;
            bus.we_n_o        <= 1'b1;
            bus.odt_o         <= 1'b0;
            bus.ba_o          <= '0;
            bus.addr_o        <= '0;
            bus.init_done_o   <= 1'b0;
        end else begin
            bus.ddr_reset_p_o <= (state == S_RST_HOLD) || (state == S_CLK_START);
            bus.phy_reset_p_o <= (state == S_RST_HOLD);
            bus.cke_o         <= !((state == S_RST_HOLD) || (state == S_CLK_START) ||
                                   (state == S_CKE_WAIT));
            bus.odt_o         <= 1'b0;
            bus.init_done_o   <= (state == S_DONE);
            bus.ras_n_o       <= 1'b1;
            bus.cas_n_o       <= 1'b1;
            bus.we_n_o        <= 1'b1;
            bus.ba_o          <= '0;
            bus.addr_o        <= '0;
            if (first) begin
                case (state)
                    S_MRS2: begin
                        {bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 3'b000;
                        bus.ba_o   <= BANK_BITS'(2);
                        bus.addr_o <= MR2;
                    end
                    S_MRS3: begin
                        {bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 3'b000;
                        bus.ba_o   <= BANK_BITS'(3);
                        bus.addr_o <= MR3;
                    end
                    S_MRS1: begin
                        {bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 3'b000;
                        bus.ba_o   <= BANK_BITS'(1);
                        bus.addr_o <= MR1;
                    end
                    S_MRS0: begin
                        {bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 3'b000;
                        bus.ba_o   <= BANK_BITS'(0);
                        bus.addr_o <= MR0;
                    end
`ifdef SDDR_INIT_ZQCL_EN
                    S_ZQCL: begin
                        {bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 3'b110;
                        bus.addr_o <= ZQ_ADDR;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sddr_init_seq.sv
// tb/tb_sddr_init_seq.sv - checks sddr_init_seq against a cycle-indexed schedule model.
// Two instances: small distinct timings (with mid-sequence resets) and all-ones timings.
module tb_sddr_init_seq;

    typedef struct packed {
        logic        ddr;
        logic        phy;
        logic        cke;
        logic        ras;
        logic        cas;
        logic        we;
        logic        odt;
        logic        done;
        logic [2:0]  ba;
        logic [12:0] addr;
    } out_t;

    localparam logic [3:0][12:0] MR_TBL = {13'h0000, 13'h0008, 13'h0044, 13'h1520};
    localparam out_t RST_VAL = '{ddr: 1'b1, phy: 1'b1, cke: 1'b0, ras: 1'b1, cas: 1'b1,
                                 we: 1'b1, odt: 1'b0, done: 1'b0, ba: 3'd0, addr: 13'd0};
`ifdef SDDR_INIT_ZQCL_EN
    localparam int DONE_A = 29;
`else
    localparam int DONE_A = 24;
`endif

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc_a = -1;
    int   cyc_b = -1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sddr_init_seq_if #(.BANK_BITS(3), .ROW_BITS(13)) bus_a ();
    sddr_init_seq_if #(.BANK_BITS(3), .ROW_BITS(13)) bus_b ();

    sddr_init_seq #(
        .RESET_CYCLES(4), .CLK_CYCLES(2), .CKE_CYCLES(6), .TXPR_CYCLES(3),
        .TMRD_CYCLES(2), .TMOD_CYCLES(3), .TZQINIT_CYCLES(5),
        .MR0(13'h1520), .MR1(13'h0044), .MR2(13'h0008), .MR3(13'h0000)
    ) dut_a (
        .in_ddr_clock_i(clk), .in_ddr_reset_n_i(rst_a), .bus(bus_a)
    );

    sddr_init_seq #(
        .RESET_CYCLES(1), .CLK_CYCLES(1), .CKE_CYCLES(1), .TXPR_CYCLES(1),
        .TMRD_CYCLES(1), .TMOD_CYCLES(1), .TZQINIT_CYCLES(1),
        .MR0(13'h1520), .MR1(13'h0044), .MR2(13'h0008), .MR3(13'h0000)
    ) dut_b (
        .in_ddr_clock_i(clk), .in_ddr_reset_n_i(rst_b), .bus(bus_b)
    );

    out_t act_a, act_b;
    assign act_a = {bus_a.ddr_reset_p_o, bus_a.phy_reset_p_o, bus_a.cke_o, bus_a.ras_n_o,
                    bus_a.cas_n_o, bus_a.we_n_o, bus_a.odt_o, bus_a.init_done_o,
                    bus_a.ba_o, bus_a.addr_o};
    assign act_b = {bus_b.ddr_reset_p_o, bus_b.phy_reset_p_o, bus_b.cke_o, bus_b.ras_n_o,
                    bus_b.cas_n_o, bus_b.we_n_o, bus_b.odt_o, bus_b.init_done_o,
                    bus_b.ba_o, bus_b.addr_o};

    // Pin values on cycle n, derived directly from the published event times
    function automatic out_t model(input int n, input int r, input int c, input int k,
                                   input int x, input int d, input int m, input int z);
        out_t o;
        int   seq [4];
        int   t;
        int   done_t;
        seq = '{2, 3, 1, 0};
        o = RST_VAL;
        o.phy = (n < r);
        o.ddr = (n < r + c);
        o.cke = (n >= r + c + k);
        t = r + c + k + x;
        for (int i = 0; i < 4; i++) begin
            if (n == t + i * d) begin
                o.ras = 1'b0; o.cas = 1'b0; o.we = 1'b0;
                o.ba = 3'(seq[i]);
                o.addr = MR_TBL[seq[i]];
            end
        end
        done_t = t + 3 * d + m;
`ifdef SDDR_INIT_ZQCL_EN
        if (n == done_t) begin
            o.we = 1'b0;
            o.addr = 13'h0400;
        end
        done_t = done_t + z;
`else
        if (z < 0) o.odt = 1'b1;
`endif
        o.done = (n >= done_t);
        return o;
    endfunction

    task automatic chk(input string name, input int cyc, input out_t act, input out_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, exp);
    endtask

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Single compare process: model check every cycle plus hand-computed pins for dut_a
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_a) begin
                cyc_a = -1;
                chk("a_reset", cyc_a, act_a, RST_VAL);
            end else begin
                cyc_a++;
                chk("a_model", cyc_a, act_a, model(cyc_a, 4, 2, 6, 3, 2, 3, 5));
                case (cyc_a)
                    3:  chk_v("a_phy_c3", 32'(act_a.phy), 32'd1);
                    4:  chk_v("a_phy_c4", 32'(act_a.phy), 32'd0);
                    5:  chk_v("a_ddr_c5", 32'(act_a.ddr), 32'd1);
                    6:  chk_v("a_ddr_c6", 32'(act_a.ddr), 32'd0);
                    11: chk_v("a_cke_c11", 32'(act_a.cke), 32'd0);
                    12: chk_v("a_cke_c12", 32'(act_a.cke), 32'd1);
                    15: chk_v("a_mrs2", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b000, 3'd2, 13'h0008});
                    16: chk_v("a_nop16", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b111, 3'd0, 13'h0000});
                    17: chk_v("a_mrs3", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b000, 3'd3, 13'h0000});
                    19: chk_v("a_mrs1", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b000, 3'd1, 13'h0044});
                    21: chk_v("a_mrs0", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b000, 3'd0, 13'h1520});
                    23: chk_v("a_done_c23", 32'(act_a.done), 32'd0);
`ifdef SDDR_INIT_ZQCL_EN
                    24: chk_v("a_zqcl", {act_a.ras, act_a.cas, act_a.we, act_a.ba, act_a.addr},
                              {3'b110, 3'd0, 13'h0400});
                    28: chk_v("a_done_c28", 32'(act_a.done), 32'd0);
                    29: chk_v("a_done_c29", 32'(act_a.done), 32'd1);
`else
                    24: chk_v("a_done_c24", {act_a.done, act_a.ras, act_a.cas, act_a.we},
                              {1'b1, 3'b111});
`endif
                    default: begin
                    end
                endcase
            end
            if (!rst_b) begin
                cyc_b = -1;
                chk("b_reset", cyc_b, act_b, RST_VAL);
            end else begin
                cyc_b++;
                if (cyc_b <= 40) chk("b_model", cyc_b, act_b, model(cyc_b, 1, 1, 1, 1, 1, 1, 1));
            end
        end
    end

    task automatic wait_a(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (cyc_a == target) return;
        end
        chk_v("a_wait_timeout", 32'(cyc_a), 32'(target));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        wait_a(8);
        rst_a = 1'b0;
        #1;
        chk("a_async_rst_cke_wait", cyc_a, act_a, RST_VAL);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;

        wait_a(19);
        rst_a = 1'b0;
        #1;
        chk("a_async_rst_mrs1", cyc_a, act_a, RST_VAL);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;

        wait_a(DONE_A + 1000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
